reduce_tree_reg: RTL and testbench

//  Parametrised, pipelined N-input logic reduction (OR/AND/XOR, optional output invert).

---
 rtl/reduce_tree_reg.sv | 127 ++++++++++++
 tb/tb_reduce_tree_reg.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reduce_tree_reg.sv
// reduce_tree_reg: pipelined N-input OR/AND/XOR reduction tree with optional
// output inversion, valid tracking and clock enable. Each stage combines
// FANIN signals per node and registers the result. A short final group in a
// stage is padded with the identity of the operator.
// Optional feature: define REDUCE_STICKY_EN to add the SCLR input and the
// sticky ZS output, which accumulates every valid Z=1 result until cleared.
module reduce_tree_reg #(
  parameter int WIDTH  = 5,
  parameter int FANIN  = 4,
  parameter int MODE   = 0,
  parameter int INVERT = 0
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             SP,
  input  logic             VI,
  input  logic [WIDTH-1:0] DI,
  output logic             Z,
  output logic             VZ
`ifdef REDUCE_STICKY_EN
  ,
  input  logic             SCLR,
  output logic             ZS
`endif
);

  // Node count after k stages; stage 0 is the operand vector itself.
  function automatic int stage_nodes(input int k);
    int n;
    n = WIDTH;
    for (int s = 0; s < k; s++) n = (n + FANIN - 1) / FANIN;
    return n;
  endfunction

  // Number of stages needed to reduce WIDTH inputs to one, never less than 1.
  function automatic int calc_lat(input int w);
    int n;
    int l;
    n = w;
    l = 0;
    while (n > 1) begin
      n = (n + FANIN - 1) / FANIN;
      l++;
    end
    if (l < 1) l = 1;
    return l;
  endfunction

  // Reduction of one padded node group with the configured operator.
  function automatic logic node_reduce(input logic [FANIN-1:0] grp);
    case (MODE)
      1:       return &grp;
      2:       return ^grp;
      default: return |grp;
    endcase
  endfunction

  localparam int   LAT   = calc_lat(WIDTH);
  localparam logic IDENT = (MODE == 1) ? 1'b1 : 1'b0;

  if (MODE < 0 || MODE > 2) begin : g_bad_mode
    $error("reduce_tree_reg: MODE must be 0 (OR), 1 (AND) or 2 (XOR)");
  end

  logic [LAT-1:0] vld_p;

  for (genvar k = 1; k <= LAT; k++) begin : g_stage
    localparam int NI   = stage_nodes(k - 1);
    localparam int NO   = stage_nodes(k);
    localparam bit LAST = (k == LAT);

    logic [NI-1:0] src;
    logic [NO-1:0] nxt;
    logic [NO-1:0] node_p;

    if (k == 1) begin : g_first
      assign src = DI;
    end else begin : g_next
      assign src = g_stage[k-1].node_p;
    end

    for (genvar j = 0; j < NO; j++) begin : g_node
      logic [FANIN-1:0] grp;
      for (genvar i = 0; i < FANIN; i++) begin : g_tap
        if (j * FANIN + i < NI) begin : g_in
          assign grp[i] = src[j*FANIN+i];
        end else begin : g_pad
          assign grp[i] = IDENT;
        end
      end
      // Inversion lives only in the last stage, ahead of its register.
      assign nxt[j] = (LAST && INVERT != 0) ? ~node_reduce(grp) : node_reduce(grp);
    end

    // ---- stage k register boundary ----
    // Data loads on every enabled edge, independent of VI.
    always_ff @(posedge CK or posedge CD) begin
      if (CD)      node_p <= '0;
      else if (SP) node_p <= nxt;
    end
  end

  // Valid shift register moving in lockstep with the data stages.
  if (LAT == 1) begin : g_vld_one
    always_ff @(posedge CK or posedge CD) begin
      if (CD)      vld_p <= 1'b0;
      else if (SP) vld_p <= VI;
    end
  end else begin : g_vld_many
    always_ff @(posedge CK or posedge CD) begin
      if (CD)      vld_p <= '0;
      else if (SP) vld_p <= {vld_p[LAT-2:0], VI};
    end
  end

  assign Z  = g_stage[LAT].node_p[0];
  assign VZ = vld_p[LAT-1];

`ifdef REDUCE_STICKY_EN
  // Sticky accumulator of valid Z=1 results; clear takes priority.
  always_ff @(posedge CK or posedge CD) begin
    if (CD)      ZS <= 1'b0;
    else if (SP) ZS <= SCLR ? 1'b0 : (ZS | (VZ & Z));
  end
`endif

endmodule

// File: tb/tb_reduce_tree_reg.sv
// Testbench for reduce_tree_reg: four configurations driven in parallel and
// compared every cycle against a latency/history reference model.
module tb_reduce_tree_reg;

  localparam int W_P [4] = '{5, 5, 16, 37};
  localparam int F_P [4] = '{4, 4, 4, 2};
  localparam int M_P [4] = '{0, 1, 2, 2};
  localparam int I_P [4] = '{0, 0, 1, 0};

  logic        CK;
  logic        CD;
  logic        SP;
  logic        VI;
  logic [4:0]  di5;
  logic [15:0] di16;
  logic [36:0] di37;
  logic [3:0]  z;
  logic [3:0]  vz;
`ifdef REDUCE_STICKY_EN
  logic        sclr;
  logic [3:0]  zs;
  logic        zs_e [4];
`endif

  int   checks;
  int   errors;
  int   n_en;
  int   lat_e [4];
  logic hv [0:4095];
  logic hz [0:3][0:4095];

  reduce_tree_reg #(.WIDTH(5), .FANIN(4), .MODE(0), .INVERT(0)) u_or (
    .CK(CK), .CD(CD), .SP(SP), .VI(VI), .DI(di5), .Z(z[0]), .VZ(vz[0])
`ifdef REDUCE_STICKY_EN
    , .SCLR(sclr), .ZS(zs[0])
`endif
  );
  reduce_tree_reg #(.WIDTH(5), .FANIN(4), .MODE(1), .INVERT(0)) u_and (
    .CK(CK), .CD(CD), .SP(SP), .VI(VI), .DI(di5), .Z(z[1]), .VZ(vz[1])
`ifdef REDUCE_STICKY_EN
    , .SCLR(sclr), .ZS(zs[1])
`endif
  );
  reduce_tree_reg #(.WIDTH(16), .FANIN(4), .MODE(2), .INVERT(1)) u_xnor (
    .CK(CK), .CD(CD), .SP(SP), .VI(VI), .DI(di16), .Z(z[2]), .VZ(vz[2])
`ifdef REDUCE_STICKY_EN
    , .SCLR(sclr), .ZS(zs[2])
`endif
  );
  reduce_tree_reg #(.WIDTH(37), .FANIN(2), .MODE(2), .INVERT(0)) u_xor37 (
    .CK(CK), .CD(CD), .SP(SP), .VI(VI), .DI(di37), .Z(z[3]), .VZ(vz[3])
`ifdef REDUCE_STICKY_EN
    , .SCLR(sclr), .ZS(zs[3])
`endif
  );

  initial CK = 1'b0;
  always #5 CK = ~CK;

  // Smallest L with FANIN**L >= WIDTH (at least 1).
  function automatic int exp_lat(input int w, input int f);
    int     l;
    longint p;
    l = 1;
    p = f;
    while (p < w) begin
      p = p * f;
      l++;
    end
    return l;
  endfunction

  // Reduction of the low w bits of v, straight from the operator definition.
  function automatic logic ref_red(input logic [36:0] v, input int w, input int mode, input int inv);
    logic [36:0] mask;
    logic        r;
    mask = {37{1'b1}} >> (37 - w);
    case (mode)
      1:       r = &(v | ~mask);
      2:       r = ^(v & mask);
      default: r = |(v & mask);
    endcase
    if (inv != 0) r = ~r;
    return r;
  endfunction

  function automatic logic [36:0] dut_in(input int i);
    case (i)
      0, 1:    return {32'b0, di5};
      2:       return {21'b0, di16};
      default: return di37;
    endcase
  endfunction

  // Expected outputs after n_en enabled edges since the last clear.
  task automatic exp_out(input int i, output logic evz, output logic ez);
    evz = 1'b0;
    ez  = 1'b0;
    if (n_en >= lat_e[i]) begin
      if (hv[n_en-lat_e[i]] === 1'b1) begin
        evz = 1'b1;
        ez  = hz[i][n_en-lat_e[i]];
      end
    end
  endtask

  task automatic check(input string tag, input logic obs, input logic expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed %b expected %b", tag, obs, expv);
    end
  endtask

  task automatic check_int(input string tag, input int obs, input int expv);
    checks++;
    assert (obs == expv) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  // One clock: update the model on enabled edges, then compare all outputs.
  task automatic tick();
    logic evz;
    logic ez;
    @(posedge CK);
    if (SP === 1'b1) begin
      for (int i = 0; i < 4; i++) begin
`ifdef REDUCE_STICKY_EN
        exp_out(i, evz, ez);
        zs_e[i] = sclr ? 1'b0 : (zs_e[i] | (evz & ez));
`endif
        hz[i][n_en] = ref_red(dut_in(i), W_P[i], M_P[i], I_P[i]);
      end
      hv[n_en] = VI;
      n_en++;
    end
    #1;
    for (int i = 0; i < 4; i++) begin
      exp_out(i, evz, ez);
      check($sformatf("vz%0d", i), vz[i], evz);
      if (evz) check($sformatf("z%0d", i), z[i], ez);
`ifdef REDUCE_STICKY_EN
      check($sformatf("zs%0d", i), zs[i], zs_e[i]);
`endif
    end
  endtask

  logic [4:0]  dir5  [4] = '{5'b00000, 5'b10000, 5'b11111, 5'b11110};
  logic [15:0] dir16 [4] = '{16'h0001, 16'h0003, 16'h0001, 16'h0003};
  logic        exp_or  [4] = '{1'b0, 1'b1, 1'b1, 1'b1};
  logic        exp_and [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
  logic        exp_xn  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
  int          vzcnt;

  initial begin
    checks = 0;
    errors = 0;
    n_en   = 0;
    for (int i = 0; i < 4; i++) lat_e[i] = exp_lat(W_P[i], F_P[i]);
    CD   = 1'b1;
    SP   = 1'b1;
    VI   = 1'b0;
    di5  = '0;
    di16 = '0;
    di37 = '0;
`ifdef REDUCE_STICKY_EN
    sclr = 1'b0;
    for (int i = 0; i < 4; i++) zs_e[i] = 1'b0;
`endif

    // Reset state while clear is held across clock edges.
    #22;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("rst_z%0d", i), z[i], 1'b0);
      check($sformatf("rst_vz%0d", i), vz[i], 1'b0);
    end
    @(posedge CK);
    #1;
    CD = 1'b0;

    // Directed operand sets with literal expectations two edges later.
    for (int k = 0; k < 6; k++) begin
      VI   = (k < 4) ? 1'b1 : 1'b0;
      di5  = (k < 4) ? dir5[k]  : 5'b0;
      di16 = (k < 4) ? dir16[k] : 16'h0;
      di37 = 37'(k);
      tick();
      if (k >= 1 && k <= 4) begin
        check($sformatf("dir_or_vz%0d", k), vz[0], 1'b1);
        check($sformatf("dir_or_z%0d", k), z[0], exp_or[k-1]);
        check($sformatf("dir_and_z%0d", k), z[1], exp_and[k-1]);
        check($sformatf("dir_xnor_z%0d", k), z[2], exp_xn[k-1]);
      end
    end

    // Randomised traffic with random enable gaps.
    for (int k = 0; k < 80; k++) begin
      SP   = ($urandom_range(0, 3) != 0);
      VI   = $urandom_range(0, 1);
      di5  = 5'($urandom);
      di16 = 16'($urandom);
      di37 = {5'($urandom), 32'($urandom)};
      if ($urandom_range(0, 3) == 0) di5 = 5'b11111;
`ifdef REDUCE_STICKY_EN
      sclr = ($urandom_range(0, 7) == 0);
`endif
      tick();
    end
    SP = 1'b1;
`ifdef REDUCE_STICKY_EN
    sclr = 1'b0;
`endif

    // Drain, then stall mid-flight for four cycles.
    VI = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    vzcnt = 0;
    for (int k = 0; k < 11; k++) begin
      SP  = (k >= 3 && k < 7) ? 1'b0 : 1'b1;
      VI  = (k < 3) ? 1'b1 : 1'b0;
      di5 = 5'($urandom);
      tick();
      if (SP && vz[0]) vzcnt++;
    end
    check_int("stall_vz_count", vzcnt, 3);
    SP = 1'b1;

    // Asynchronous clear with two words in flight.
    VI = 1'b1;
    for (int k = 0; k < 2; k++) begin
      di5  = 5'b10000;
      di16 = 16'h0001;
      di37 = 37'h1;
      tick();
    end
    VI = 1'b0;
    #2 CD = 1'b1;
    #1;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("cd_z%0d", i), z[i], 1'b0);
      check($sformatf("cd_vz%0d", i), vz[i], 1'b0);
    end
    #1 CD = 1'b0;
    n_en = 0;
`ifdef REDUCE_STICKY_EN
    for (int i = 0; i < 4; i++) zs_e[i] = 1'b0;
`endif
    for (int k = 0; k < 8; k++) tick();

    // Unknown operands without valid must not disturb VZ.
    VI   = 1'b0;
    di5  = 'x;
    di16 = 'x;
    di37 = 'x;
    for (int k = 0; k < 3; k++) tick();
    di5  = '0;
    di16 = '0;
    di37 = '0;
    for (int k = 0; k < 8; k++) tick();

`ifdef REDUCE_STICKY_EN
    // Sticky: a single valid Z=1 result is held; clear wins over a new one.
    sclr = 1'b1;
    tick();
    sclr = 1'b0;
    VI  = 1'b1;
    di5 = 5'b10000;
    tick();
    VI  = 1'b0;
    di5 = 5'b0;
    for (int k = 0; k < 5; k++) tick();
    check("sticky_hold", zs[0], 1'b1);
    VI  = 1'b1;
    di5 = 5'b10000;
    tick();
    VI  = 1'b0;
    di5 = 5'b0;
    tick();
    sclr = 1'b1;
    tick();
    check("sticky_clear_wins", zs[0], 1'b0);
    sclr = 1'b0;
    tick();
    check("sticky_after_clear", zs[0], 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
